// File: rtl/rf_pkg.sv
// Shared constants for the register-file access controller: default widths and FSM state encoding.
package rf_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_READ     = 3'd1;
    localparam logic [2:0] ST_OPER     = 3'd2;
    localparam logic [2:0] ST_WAIT_RES = 3'd3;
    localparam logic [2:0] ST_WRITE    = 3'd4;

endpackage

// File: rtl/regfile_access_ctrl.sv
// Register-file initiator: fetches two operands, hands them to execute, writes back one result.
// Build option RF_R0_ZERO_EN: register 0 reads as zero and writes to it are dropped.
module regfile_access_ctrl
    import rf_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_rs,
    input  logic [ADDR_W-1:0] req_rt,
    input  logic [ADDR_W-1:0] req_rd,
    input  logic              req_wb,
    output logic [ADDR_W-1:0] rf_ra,
    output logic [ADDR_W-1:0] rf_rb,
    input  logic [DATA_W-1:0] rf_rda,
    input  logic [DATA_W-1:0] rf_rdb,
    output logic [ADDR_W-1:0] rf_wr,
    output logic [DATA_W-1:0] rf_wd,
    output logic              rf_we,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    input  logic              res_valid,
    output logic              res_ready,
    input  logic [DATA_W-1:0] res_data,
    output logic              busy
);

    logic [2:0]        state;
    logic [ADDR_W-1:0] rs_q, rt_q, rd_q;
    logic              wb_q;
    logic [DATA_W-1:0] op_a_q, op_b_q, res_q;
    logic [DATA_W-1:0] rda_eff, rdb_eff;
    logic              wr_ok;

`ifdef RF_R0_ZERO_EN
    assign rda_eff = (rs_q == '0) ? '0 : rf_rda;
    assign rdb_eff = (rt_q == '0) ? '0 : rf_rdb;
    assign wr_ok   = (rd_q != '0);
`else
    assign rda_eff = rf_rda;
    assign rdb_eff = rf_rdb;
    assign wr_ok   = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            rs_q   <= '0;
            rt_q   <= '0;
            rd_q   <= '0;
            wb_q   <= 1'b0;
            op_a_q <= '0;
            op_b_q <= '0;
            res_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        rs_q  <= req_rs;
                        rt_q  <= req_rt;
                        rd_q  <= req_rd;
                        wb_q  <= req_wb;
                        state <= ST_READ;
                    end
                end
                ST_READ: begin
                    // Operands are sampled exactly once; later writes never refresh them.
                    op_a_q <= rda_eff;
                    op_b_q <= rdb_eff;
                    state  <= ST_OPER;
                end
                ST_OPER: begin
                    if (op_ready) state <= wb_q ? ST_WAIT_RES : ST_IDLE;
                end
                ST_WAIT_RES: begin
                    if (res_valid) begin
                        res_q <= res_data;
                        state <= ST_WRITE;
                    end
                end
                ST_WRITE: state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready = (state == ST_IDLE);
    assign op_valid  = (state == ST_OPER);
    assign res_ready = (state == ST_WAIT_RES);
    assign busy      = (state != ST_IDLE);

    assign rf_ra = rs_q;
    assign rf_rb = rt_q;
    assign rf_wr = rd_q;
    assign rf_wd = res_q;
    assign op_a  = op_a_q;
    assign op_b  = op_b_q;

    // Gating with rst_n lets a reset landing on the WRITE cycle cancel the write.
    assign rf_we = (state == ST_WRITE) & rst_n & wr_ok;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl: directed scenarios plus random traffic against a transaction-level model.
module tb_regfile_access_ctrl;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_wb, req_ready;
    logic [AW-1:0] req_rs, req_rt, req_rd;
    logic [AW-1:0] rf_ra, rf_rb, rf_wr;
    logic [DW-1:0] rf_rda, rf_rdb, rf_wd;
    logic          rf_we;
    logic          op_valid, op_ready;
    logic [DW-1:0] op_a, op_b;
    logic          res_valid, res_ready;
    logic [DW-1:0] res_data;
    logic          busy;

    int n_chk  = 0;
    int n_fail = 0;

    // Bench-owned register file; a back door preloads it while the controller is idle.
    logic [DW-1:0] regs [32] = '{default: '0};
    logic          tb_we;
    logic [AW-1:0] tb_wa;
    logic [DW-1:0] tb_wd;
    int            we_pulses = 0;

    always #5 clk = ~clk;

    assign rf_rda = regs[rf_ra];
    assign rf_rdb = regs[rf_rb];

    always @(posedge clk) begin
        if (rf_we) begin
            regs[rf_wr] <= rf_wd;
            we_pulses   <= we_pulses + 1;
        end else if (tb_we) begin
            regs[tb_wa] <= tb_wd;
        end
    end

    regfile_access_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_wb(req_wb),
        .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_rda(rf_rda), .rf_rdb(rf_rdb),
        .rf_wr(rf_wr), .rf_wd(rf_wd), .rf_we(rf_we),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .busy(busy)
    );

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rd_val(input logic [DW-1:0] v, input logic [AW-1:0] idx);
`ifdef RF_R0_ZERO_EN
        return (idx == 0) ? '0 : v;
`else
        return v;
`endif
    endfunction

    function automatic bit wr_allowed(input logic [AW-1:0] idx);
`ifdef RF_R0_ZERO_EN
        return idx != 0;
`else
        return 1'b1;
`endif
    endfunction

    // Transaction-level model: one outstanding request, described by the cycles
    // at which it was accepted, its operands were taken and its result was taken.
    logic [DW-1:0] mdl_regs [32] = '{default: '0};

    initial begin
        int            cyc;
        bit            m_busy, m_opd, m_resd, m_wb;
        int            acc_c, res_c;
        logic [AW-1:0] m_rs, m_rt, m_rd;
        logic [DW-1:0] m_a, m_b, m_res;
        bit            e_opv, e_rr, e_wcyc, e_we;
        cyc = 0; m_busy = 0; m_opd = 0; m_resd = 0; m_wb = 0;
        acc_c = 0; res_c = 0; m_rs = 0; m_rt = 0; m_rd = 0;
        m_a = 0; m_b = 0; m_res = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                chk("we_in_reset", rf_we, 1'b0);
                m_busy = 0;
            end else begin
                e_opv  = m_busy && (cyc >= acc_c + 2) && !m_opd;
                e_rr   = m_busy && m_wb && m_opd && !m_resd;
                e_wcyc = m_busy && m_resd && (cyc == res_c + 1);
                e_we   = e_wcyc && wr_allowed(m_rd);
                chk("req_ready", req_ready, !m_busy);
                chk("busy", busy, m_busy);
                chk("op_valid", op_valid, e_opv);
                chk("res_ready", res_ready, e_rr);
                chk("rf_we", rf_we, e_we);
                if (e_opv) begin
                    chk("op_a", op_a, m_a);
                    chk("op_b", op_b, m_b);
                end
                if (m_busy && cyc >= acc_c + 1) begin
                    chk("rf_ra", rf_ra, m_rs);
                    chk("rf_rb", rf_rb, m_rt);
                end
                if (e_we) begin
                    chk("rf_wr", rf_wr, m_rd);
                    chk("rf_wd", rf_wd, m_res);
                end
                if (e_wcyc) begin
                    if (wr_allowed(m_rd)) mdl_regs[m_rd] = m_res;
                    m_busy = 0;
                end else if (e_opv && op_ready) begin
                    m_opd = 1;
                    if (!m_wb) m_busy = 0;
                end else if (e_rr && res_valid) begin
                    m_resd = 1; res_c = cyc; m_res = res_data;
                end else if (!m_busy && req_valid) begin
                    m_busy = 1; acc_c = cyc; m_opd = 0; m_resd = 0;
                    m_rs = req_rs; m_rt = req_rt; m_rd = req_rd; m_wb = req_wb;
                    m_a = rd_val(mdl_regs[req_rs], req_rs);
                    m_b = rd_val(mdl_regs[req_rt], req_rt);
                end
                if (tb_we) mdl_regs[tb_wa] = tb_wd;
            end
        end
    end

    task automatic wait_idle(input string nm);
        for (int i = 0; i < 40; i++) begin
            if (!busy) break;
            tick;
        end
        chk(nm, busy, 1'b0);
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        tb_we = 1'b1; tb_wa = a; tb_wd = d;
        tick;
        tb_we = 1'b0;
    endtask

    task automatic issue(input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                         input logic [AW-1:0] rd, input logic wb);
        req_valid = 1'b1; req_rs = rs; req_rt = rt; req_rd = rd; req_wb = wb;
        tick;
        req_valid = 1'b0;
    endtask

    initial begin
        int            p0, acc_n, cyc_n;
        int            acc [3];
        logic [DW-1:0] prev;
        rst_n = 1'b0; req_valid = 0; req_rs = 0; req_rt = 0; req_rd = 0; req_wb = 0;
        op_ready = 0; res_valid = 0; res_data = 0; tb_we = 0; tb_wa = 0; tb_wd = 0;
        repeat (3) tick;
        rst_n = 1'b1;
        tick;
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_op_valid", op_valid, 1'b0);
        chk("rst_res_ready", res_ready, 1'b0);
        chk("rst_op_a", op_a, 32'h0);
        chk("rst_rf_wd", rf_wd, 32'h0);
        chk("rst_rf_ra", rf_ra, 5'd0);

        preload(5'd2, 32'h14);
        preload(5'd1, 32'hf0f0f0f0);
        preload(5'd0, 32'hf0f0f0f0);

        // Read-only request; operands appear two cycles after accept.
        p0 = we_pulses;
        issue(5'd2, 5'd1, 5'd0, 1'b0);
        chk("read_no_opv", op_valid, 1'b0);
        tick;
        chk("dir_op_valid", op_valid, 1'b1);
        chk("dir_op_a", op_a, 32'h14);
        chk("dir_op_b", op_b, 32'hf0f0f0f0);
        req_valid = 1'b1; req_rs = 5'd7;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("stall_op_a", op_a, 32'h14);
            chk("stall_op_b", op_b, 32'hf0f0f0f0);
            chk("stall_req_ready", req_ready, 1'b0);
        end
        req_valid = 1'b0; op_ready = 1'b1;
        tick;
        op_ready = 1'b0;
        chk("nowb_idle", req_ready, 1'b1);
        chk("nowb_no_we", we_pulses - p0, 0);

        // Writeback request and read-back of the written register.
        p0 = we_pulses;
        op_ready = 1'b1; res_valid = 1'b1; res_data = 32'h1234;
        issue(5'd1, 5'd2, 5'd3, 1'b1);
        tick; tick; tick;
        chk("wb_we", rf_we, 1'b1);
        chk("wb_wr", rf_wr, 5'd3);
        chk("wb_wd", rf_wd, 32'h1234);
        tick;
        chk("wb_we_drop", rf_we, 1'b0);
        chk("wb_pulses", we_pulses - p0, 1);
        chk("wb_r3", regs[3], 32'h1234);
        res_valid = 1'b0;
        issue(5'd3, 5'd3, 5'd0, 1'b0);
        tick;
        chk("rb_op_a", op_a, 32'h1234);
        wait_idle("rb_idle");

        // Index-0 behaviour.
        res_valid = 1'b1; res_data = 32'h55;
        issue(5'd0, 5'd2, 5'd0, 1'b1);
        tick;
`ifdef RF_R0_ZERO_EN
        chk("r0_op_a", op_a, 32'h0);
`else
        chk("r0_op_a", op_a, 32'hf0f0f0f0);
`endif
        chk("r0_op_b", op_b, 32'h14);
        wait_idle("r0_idle");
        tick;
`ifdef RF_R0_ZERO_EN
        chk("r0_kept", regs[0], 32'hf0f0f0f0);
`else
        chk("r0_written", regs[0], 32'h55);
`endif

        // Back-to-back requests with writeback: accepts spaced 5 cycles apart.
        req_valid = 1'b1; req_rs = 5'd4; req_rt = 5'd5; req_rd = 5'd6; req_wb = 1'b1;
        res_data = 32'h77;
        acc_n = 0; cyc_n = 0;
        while (acc_n < 3 && cyc_n < 40) begin
            if (req_ready) begin acc[acc_n] = cyc_n; acc_n++; end
            tick;
            cyc_n++;
        end
        req_valid = 1'b0;
        chk("b2b_count", acc_n, 3);
        if (acc_n == 3) begin
            chk("b2b_gap1", acc[1] - acc[0], 5);
            chk("b2b_gap2", acc[2] - acc[1], 5);
        end
        wait_idle("b2b_idle");

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            req_valid = ($urandom_range(0, 2) != 0);
            req_rs    = AW'($urandom);
            req_rt    = AW'($urandom);
            req_rd    = AW'($urandom);
            req_wb    = $urandom_range(0, 1) != 0;
            op_ready  = ($urandom_range(0, 2) != 0);
            res_valid = ($urandom_range(0, 2) != 0);
            res_data  = $urandom;
            tick;
        end
        req_valid = 1'b0; op_ready = 1'b1; res_valid = 1'b1;
        wait_idle("rand_idle");
        tick;
        for (int r = 0; r < 32; r++) chk($sformatf("regs_%0d", r), regs[r], mdl_regs[r]);

        // Reset landing on the WRITE cycle cancels the write.
        prev = regs[9];
        res_data = prev ^ 32'hdead_beef;
        issue(5'd1, 5'd2, 5'd9, 1'b1);
        for (int i = 0; i < 20; i++) begin
            if (rf_we) break;
            tick;
        end
        chk("rstw_reached", rf_we, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rstw_we_low", rf_we, 1'b0);
        tick;
        rst_n = 1'b1;
        chk("rstw_req_ready", req_ready, 1'b1);
        chk("rstw_busy", busy, 1'b0);
        chk("rstw_r9", regs[9], prev);
        op_ready = 1'b0; res_valid = 1'b0;
        repeat (3) tick;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
